// File: rtl/wb_pipe_reg_multi_pkg.sv
// ---------------------------------------------------------------------------
// wb_pipe_reg_multi_pkg
//
// Shared pipeline constants used by the multi-lane MEM/WB register:
//   - NOPRegAddr   : the hard-wired zero register (x0) address
//   - WriteEnable / WriteDisable : write-enable encodings
//   - ZeroWord     : all-zero register data word
//   - StallBus     : width of the controller's stall vector
//   - Stage*       : stall-vector bit index owned by each pipeline stage
//   - stage_action_e / stage_action() : what a pipeline register does on
//     the next clock edge, derived from flush and the stall vector
// ---------------------------------------------------------------------------
package wb_pipe_reg_multi_pkg;

    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    localparam int StallBus = 7;

    // Stall-vector bit owned by each stage. Bit 6 is whatever sits after
    // writeback (e.g. a retire/commit unit).
    localparam int StagePc  = 0;
    localparam int StageIf  = 1;
    localparam int StageId  = 2;
    localparam int StageEx  = 3;
    localparam int StageMem = 4;
    localparam int StageWb  = 5;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } stage_action_e;

    // Flush beats everything, including a stalled downstream stage: squashed
    // work must never linger in writeback. A stage that is stalled while its
    // consumer keeps running emits a bubble so the consumer does not replay
    // the previous instruction.
    function automatic stage_action_e stage_action(
        input logic flush,
        input logic own_stall,
        input logic down_stall
    );
        stage_action_e act;
        if (flush) begin
            act = ACT_BUBBLE;
        end else if (own_stall && !down_stall) begin
            act = ACT_BUBBLE;
        end else if (!own_stall) begin
            act = ACT_LOAD;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/wb_pipe_reg_multi_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Unsigned up-counter that sticks at its maximum value instead of wrapping.
//   clk : clock
//   rst : synchronous active-high reset, clears q
//   clr : synchronous clear, clears q and overrides inc
//   inc : count one event this cycle
//   q   : current count (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Clearing wins over counting; at all-ones further events are dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/wb_pipe_reg_multi.sv
// ---------------------------------------------------------------------------
// wb_pipe_reg_multi
//
// Multi-lane MEM/WB pipeline register. Carries LANES writeback slots
// (destination register, write enable, data) from MEM to WB. Lane 0 holds
// the oldest instruction of the group.
//
// On load, each lane is filtered before being registered:
//   - a write to x0 is dropped and its data zeroed,
//   - if two lanes write the same register, only the youngest stays enabled
//     (older lanes keep their address and data, just lose the enable).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   stall_sign   : stall vector from the pipeline controller
//   flush        : squash this stage (exception / redirect)
//   mem_wd       : per-lane destination register, lane i at [i*ADDR_W +: ADDR_W]
//   mem_wreg     : per-lane write enable
//   mem_wdata    : per-lane write data, lane i at [i*DATA_W +: DATA_W]
//   wb_wd        : registered destination registers
//   wb_wreg      : registered write enables
//   wb_wdata     : registered write data
//   wb_any       : OR of wb_wreg (any lane writes this cycle)
//   cnt_clr      : synchronous clear of both performance counters
//   bubble_cnt   : saturating count of bubble cycles
//   hold_cnt     : saturating count of hold cycles
// ---------------------------------------------------------------------------
module wb_pipe_reg_multi
    import wb_pipe_reg_multi_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int STALL_W   = StallBus,
    parameter int STAGE_IDX = StageWb,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall_sign,
    input  logic                    flush,
    input  logic [LANES*ADDR_W-1:0] mem_wd,
    input  logic [LANES-1:0]        mem_wreg,
    input  logic [LANES*DATA_W-1:0] mem_wdata,
    output logic [LANES*ADDR_W-1:0] wb_wd,
    output logic [LANES-1:0]        wb_wreg,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic                    wb_any,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        hold_cnt
);

    localparam logic [ADDR_W-1:0] NopAddr  = ADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0] ZeroData = DATA_W'(ZeroWord);

    stage_action_e action;

    logic [LANES-1:0]        lane_enabled;
    logic [LANES-1:0]        waw_kill;
    logic [LANES*ADDR_W-1:0] filt_wd;
    logic [LANES-1:0]        filt_wreg;
    logic [LANES*DATA_W-1:0] filt_data;

    assign action = stage_action(flush,
                                 stall_sign[STAGE_IDX],
                                 stall_sign[STAGE_IDX+1]);

    // Per-lane filter. lane_enabled is the write enable after x0 suppression;
    // an older lane loses its enable if any younger lane also writes the same
    // register. The youngest lane has nobody younger, so with LANES=1 no
    // comparison logic is generated at all.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic is_x0;

        assign is_x0 = (mem_wd[i*ADDR_W +: ADDR_W] == NopAddr);
        assign lane_enabled[i] = mem_wreg[i] && !is_x0;

        if (i < LANES - 1) begin : g_waw
            logic [LANES-1:0] younger_hit;
            for (genvar j = 0; j < LANES; j++) begin : g_cmp
                if (j > i) begin : g_younger
                    assign younger_hit[j] = lane_enabled[j] &&
                        (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W]);
                end else begin : g_older
                    assign younger_hit[j] = 1'b0;
                end
            end
            assign waw_kill[i] = |younger_hit;
        end else begin : g_last
            assign waw_kill[i] = 1'b0;
        end

        // Only x0 suppression zeroes a lane; disabled or WAW-killed lanes pass
        // their address and data through untouched.
        assign filt_wreg[i] = lane_enabled[i] && !waw_kill[i];
        assign filt_wd[i*ADDR_W +: ADDR_W] =
            is_x0 ? NopAddr : mem_wd[i*ADDR_W +: ADDR_W];
        assign filt_data[i*DATA_W +: DATA_W] =
            is_x0 ? ZeroData : mem_wdata[i*DATA_W +: DATA_W];
    end

    // Writeback slot registers. Hold simply leaves the registers alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd    <= {LANES{NopAddr}};
            wb_wreg  <= {LANES{WriteDisable}};
            wb_wdata <= {LANES{ZeroData}};
        end else begin
            case (action)
                ACT_BUBBLE: begin
                    wb_wd    <= {LANES{NopAddr}};
                    wb_wreg  <= {LANES{WriteDisable}};
                    wb_wdata <= {LANES{ZeroData}};
                end
                ACT_LOAD: begin
                    wb_wd    <= filt_wd;
                    wb_wreg  <= filt_wreg;
                    wb_wdata <= filt_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_any = |wb_wreg;

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (action == ACT_BUBBLE),
        .q   (bubble_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (action == ACT_HOLD),
        .q   (hold_cnt)
    );

endmodule

// File: tb/tb_wb_pipe_reg_multi.sv
// ---------------------------------------------------------------------------
// tb_wb_pipe_reg_multi
//
// Directed bench for wb_pipe_reg_multi with LANES=2 and 4-bit counters.
// A behavioural model tracks the expected writeback slots and counters from
// the stage rules; a compare process checks the DUT against it every cycle,
// and the directed sequence adds literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_wb_pipe_reg_multi;

    localparam int LANES   = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int STALL_W = 7;
    localparam int STAGE   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_W-1:0]      stall_sign;
    logic                    flush;
    logic [LANES*ADDR_W-1:0] mem_wd;
    logic [LANES-1:0]        mem_wreg;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [LANES*ADDR_W-1:0] wb_wd;
    logic [LANES-1:0]        wb_wreg;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic                    wb_any;
    logic                    cnt_clr;
    logic [CNT_W-1:0]        bubble_cnt;
    logic [CNT_W-1:0]        hold_cnt;

    int checks   = 0;
    int failures = 0;

    wb_pipe_reg_multi #(
        .LANES     (LANES),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STALL_W   (STALL_W),
        .STAGE_IDX (STAGE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_sign (stall_sign),
        .flush      (flush),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .wb_any     (wb_any),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt)
    );

    always #5 clk = ~clk;

    // Compare one value and report on mismatch.
    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural model: expected writeback slots and counter values.
    logic [ADDR_W-1:0] m_wd   [LANES];
    logic              m_wreg [LANES];
    logic [DATA_W-1:0] m_data [LANES];
    int                m_bub  = 0;
    int                m_hold = 0;
    bit                model_valid = 1'b0;

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        logic [ADDR_W-1:0] in_wd   [LANES];
        logic              in_en   [LANES];
        logic [DATA_W-1:0] in_data [LANES];
        bit                do_bubble;
        bit                do_hold;
        do_bubble = 1'b0;
        do_hold   = 1'b0;
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                m_wd[i] = '0; m_wreg[i] = 1'b0; m_data[i] = '0;
            end
            m_bub = 0;
            m_hold = 0;
            model_valid = 1'b1;
        end else begin
            if (flush || (stall_sign[STAGE] && !stall_sign[STAGE+1])) begin
                do_bubble = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    m_wd[i] = '0; m_wreg[i] = 1'b0; m_data[i] = '0;
                end
            end else if (!stall_sign[STAGE]) begin
                for (int i = 0; i < LANES; i++) begin
                    in_wd[i]   = mem_wd[i*ADDR_W +: ADDR_W];
                    in_data[i] = mem_wdata[i*DATA_W +: DATA_W];
                    in_en[i]   = mem_wreg[i] && (in_wd[i] != 0);
                end
                for (int i = 0; i < LANES; i++) begin
                    bit younger_writes;
                    younger_writes = 1'b0;
                    for (int j = i + 1; j < LANES; j++)
                        if (in_en[j] && in_wd[j] == in_wd[i]) younger_writes = 1'b1;
                    if (in_wd[i] == 0) begin
                        m_wd[i] = '0; m_wreg[i] = 1'b0; m_data[i] = '0;
                    end else begin
                        m_wd[i]   = in_wd[i];
                        m_wreg[i] = in_en[i] && !younger_writes;
                        m_data[i] = in_data[i];
                    end
                end
            end else begin
                do_hold = 1'b1;
            end
            if (cnt_clr) begin
                m_bub = 0;
                m_hold = 0;
            end else begin
                if (do_bubble && m_bub < CNT_MAX) m_bub++;
                if (do_hold && m_hold < CNT_MAX) m_hold++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [LANES*ADDR_W-1:0] e_wd;
            logic [LANES-1:0]        e_wreg;
            logic [LANES*DATA_W-1:0] e_data;
            for (int i = 0; i < LANES; i++) begin
                e_wd[i*ADDR_W +: ADDR_W]   = m_wd[i];
                e_wreg[i]                  = m_wreg[i];
                e_data[i*DATA_W +: DATA_W] = m_data[i];
            end
            check_output("model_wb_wd", 64'(wb_wd), 64'(e_wd));
            check_output("model_wb_wreg", 64'(wb_wreg), 64'(e_wreg));
            check_output("model_wb_wdata", 64'(wb_wdata), 64'(e_data));
            check_output("model_wb_any", 64'(wb_any), 64'(|e_wreg));
            check_output("model_bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
            check_output("model_hold_cnt", 64'(hold_cnt), 64'(m_hold));
        end
    end

    // Drive one cycle of inputs and wait until the edge that consumes them
    // has passed (returns on the following falling edge).
    task automatic apply_stimulus(
        input logic r, input logic [STALL_W-1:0] st, input logic fl, input logic cc,
        input logic [ADDR_W-1:0] wd0, input logic w0, input logic [DATA_W-1:0] d0,
        input logic [ADDR_W-1:0] wd1, input logic w1, input logic [DATA_W-1:0] d1
    );
        rst        = r;
        stall_sign = st;
        flush      = fl;
        cnt_clr    = cc;
        mem_wd     = {wd1, wd0};
        mem_wreg   = {w1, w0};
        mem_wdata  = {d1, d0};
        @(negedge clk);
    endtask

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_OWN  = 7'b0100000;
    localparam logic [6:0] S_BOTH = 7'b1100000;
    localparam logic [6:0] S_DOWN = 7'b1000000;

    initial begin
        // Reset with nonzero inputs for two cycles.
        apply_stimulus(1, S_NONE, 0, 0, 5'd3, 1, 32'h11, 5'd7, 1, 32'h22);
        apply_stimulus(1, S_NONE, 0, 0, 5'd3, 1, 32'h11, 5'd7, 1, 32'h22);
        check_output("reset_wd", 64'(wb_wd), 64'd0);
        check_output("reset_wreg", 64'(wb_wreg), 64'd0);
        check_output("reset_wdata", 64'(wb_wdata), 64'd0);
        check_output("reset_any", 64'(wb_any), 64'd0);
        check_output("reset_bubble", 64'(bubble_cnt), 64'd0);
        check_output("reset_hold", 64'(hold_cnt), 64'd0);

        // Plain load, one cycle latency.
        apply_stimulus(0, S_NONE, 0, 0, 5'd3, 1, 32'h11, 5'd7, 1, 32'h22);
        check_output("load_wd", 64'(wb_wd), 64'({5'd7, 5'd3}));
        check_output("load_wreg", 64'(wb_wreg), 64'(2'b11));
        check_output("load_wdata", 64'(wb_wdata), {32'h22, 32'h11});
        check_output("load_any", 64'(wb_any), 64'd1);

        // WAW: older lane loses its enable but keeps address and data.
        apply_stimulus(0, S_NONE, 0, 0, 5'd4, 1, 32'hAA, 5'd4, 1, 32'hBB);
        check_output("waw_wd", 64'(wb_wd), 64'({5'd4, 5'd4}));
        check_output("waw_wreg", 64'(wb_wreg), 64'(2'b10));
        check_output("waw_wdata", 64'(wb_wdata), {32'hBB, 32'hAA});

        // x0 suppression on lane 0; disabled lane 1 passes through unchanged.
        apply_stimulus(0, S_NONE, 0, 0, 5'd0, 1, 32'h55, 5'd9, 0, 32'h66);
        check_output("x0_wd", 64'(wb_wd), 64'({5'd9, 5'd0}));
        check_output("x0_wreg", 64'(wb_wreg), 64'(2'b00));
        check_output("x0_wdata", 64'(wb_wdata), {32'h66, 32'h0});
        check_output("x0_any", 64'(wb_any), 64'd0);

        // Own stall with downstream running: bubble.
        apply_stimulus(0, S_OWN, 0, 0, 5'd1, 1, 32'h1234, 5'd2, 1, 32'h5678);
        check_output("stall_bubble_wreg", 64'(wb_wreg), 64'd0);
        check_output("stall_bubble_wd", 64'(wb_wd), 64'd0);
        check_output("stall_bubble_cnt", 64'(bubble_cnt), 64'd1);

        // Load then hold for three cycles with changing inputs.
        apply_stimulus(0, S_NONE, 0, 0, 5'd5, 1, 32'h1, 5'd6, 1, 32'h2);
        for (int k = 0; k < 3; k++)
            apply_stimulus(0, S_BOTH, 0, 0, 5'(10 + k), 1, 32'(k + 100), 5'd11, 1, 32'hF);
        check_output("hold_wd", 64'(wb_wd), 64'({5'd6, 5'd5}));
        check_output("hold_wdata", 64'(wb_wdata), {32'h2, 32'h1});
        check_output("hold_cnt3", 64'(hold_cnt), 64'd3);

        // Release: lane 1 disabled, so lane 0 keeps its enable on the same rd.
        apply_stimulus(0, S_NONE, 0, 0, 5'd8, 1, 32'h3, 5'd8, 0, 32'h4);
        check_output("release_wreg", 64'(wb_wreg), 64'(2'b01));
        check_output("release_wdata", 64'(wb_wdata), {32'h4, 32'h3});

        // Flush beats a full stall.
        apply_stimulus(0, S_BOTH, 1, 0, 5'd12, 1, 32'h9, 5'd13, 1, 32'hA);
        check_output("flush_wreg", 64'(wb_wreg), 64'd0);
        check_output("flush_bubble", 64'(bubble_cnt), 64'd2);
        check_output("flush_hold", 64'(hold_cnt), 64'd3);
        apply_stimulus(0, S_NONE, 1, 0, 5'd12, 1, 32'h9, 5'd13, 1, 32'hA);
        check_output("flush_alone_bubble", 64'(bubble_cnt), 64'd3);

        // Reset during a held state clears everything.
        apply_stimulus(0, S_NONE, 0, 0, 5'd1, 1, 32'hC, 5'd2, 1, 32'hD);
        apply_stimulus(0, S_BOTH, 0, 0, 5'd1, 1, 32'hC, 5'd2, 1, 32'hD);
        apply_stimulus(1, S_BOTH, 0, 0, 5'd1, 1, 32'hC, 5'd2, 1, 32'hD);
        check_output("rst_hold_wdata", 64'(wb_wdata), 64'd0);
        check_output("rst_hold_cnt", 64'(hold_cnt), 64'd0);
        check_output("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);

        // Saturation: 20 holds leave hold_cnt at 15.
        apply_stimulus(0, S_NONE, 0, 0, 5'd2, 1, 32'h77, 5'd3, 1, 32'h88);
        for (int k = 0; k < 20; k++)
            apply_stimulus(0, S_BOTH, 0, 0, 5'd20, 1, 32'hEE, 5'd21, 1, 32'hFF);
        check_output("sat_hold", 64'(hold_cnt), 64'd15);
        check_output("sat_data_held", 64'(wb_wdata), {32'h88, 32'h77});

        // Clear overrides an increment and leaves the data path alone.
        apply_stimulus(0, S_BOTH, 0, 1, 5'd20, 1, 32'hEE, 5'd21, 1, 32'hFF);
        check_output("clr_hold", 64'(hold_cnt), 64'd0);
        check_output("clr_data_held", 64'(wb_wdata), {32'h88, 32'h77});
        apply_stimulus(0, S_OWN, 0, 1, 5'd20, 1, 32'hEE, 5'd21, 1, 32'hFF);
        check_output("clr_bubble", 64'(bubble_cnt), 64'd0);
        apply_stimulus(0, S_BOTH, 0, 0, 5'd20, 1, 32'hEE, 5'd21, 1, 32'hFF);
        check_output("after_clr_hold", 64'(hold_cnt), 64'd1);

        // Downstream-only stall still loads; further directed filter cases.
        apply_stimulus(0, S_DOWN, 0, 0, 5'd14, 1, 32'h140, 5'd15, 1, 32'h150);
        check_output("down_only_load", 64'(wb_wd), 64'({5'd15, 5'd14}));
        apply_stimulus(0, S_NONE, 0, 0, 5'd0, 1, 32'h1, 5'd0, 1, 32'h2);
        check_output("both_x0_wdata", 64'(wb_wdata), 64'd0);
        apply_stimulus(0, S_NONE, 0, 0, 5'd5, 0, 32'h50, 5'd5, 1, 32'h51);
        check_output("older_off_wreg", 64'(wb_wreg), 64'(2'b10));
        apply_stimulus(0, S_NONE, 0, 0, 5'd31, 1, 32'hFFFF_FFFF, 5'd30, 1, 32'h0);
        check_output("distinct_wreg", 64'(wb_wreg), 64'(2'b11));
        apply_stimulus(0, S_NONE, 0, 0, 5'd6, 1, 32'h60, 5'd0, 1, 32'h61);
        check_output("lane1_x0_wreg", 64'(wb_wreg), 64'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg_multi.md
Name: wb_pipe_reg_multi

Overview:
Parametrised successor to the single-lane MEM/WB pipeline register. It carries LANES parallel writeback slots (rd address, write enable, data) from the MEM stage to the WB stage. It is driven by the shared stall vector and adds three behaviours: an explicit flush, x0-write suppression, and same-cycle write-after-write resolution between lanes. Saturating performance counters record bubble and hold cycles.

Parameters:
LANES, 2, number of parallel writeback lanes (1..4); lane 0 is the oldest instruction.
ADDR_W, 5, register-address width.
DATA_W, 32, register-data width.
STALL_W, 7, width of the stall vector.
STAGE_IDX, 5, stall bit owned by this stage; bit STAGE_IDX+1 is the downstream stage (requires STAGE_IDX+1 < STALL_W).
CNT_W, 16, performance-counter width.

Ports:
clk  in  1  clock
rst  in  1  reset
stall_sign  in  STALL_W  pipeline stall vector from ctrl
flush  in  1  squash the contents of this stage (exception/redirect)
mem_wd  in  LANES*ADDR_W  per-lane destination register; lane i at bits [i*ADDR_W +: ADDR_W]
mem_wreg  in  LANES  per-lane write enable
mem_wdata  in  LANES*DATA_W  per-lane write data
wb_wd  out  LANES*ADDR_W  registered destination register
wb_wreg  out  LANES  registered write enable
wb_wdata  out  LANES*DATA_W  registered write data
wb_any  out  1  combinational OR of wb_wreg
cnt_clr  in  1  synchronous clear of both counters
bubble_cnt  out  CNT_W  cycles in which a bubble was inserted
hold_cnt  out  CNT_W  cycles in which the contents were held

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. In the rst cycle all lanes take wd=0, wreg=0, data=0, and both counters are cleared.
- Priority per posedge, first match wins:
  - rst.
  - flush: bubble.
  - stall[STAGE_IDX] && !stall[STAGE_IDX+1]: bubble.
  - !stall[STAGE_IDX]: load.
  - otherwise: hold.
- Bubble: every lane becomes wd=0, wreg=0, data=0.
- Hold: all outputs keep their previous values.
- Load: each lane registers its filtered inputs. Latency is 1 cycle, and wb_any follows wb_wreg combinationally.
- Filtering happens before registering, on load only:
  - x0 suppression: if mem_wd[i]==0, lane i stores wreg=0 and data=0 (wd=0).
  - WAW resolution: if lanes i<j both have wreg=1 after x0 suppression and equal wd, lane i stores wreg=0 and keeps its wd and data. Only the youngest writer of a register stays enabled.
  - Lanes with wreg=0 at input store their wd and data unchanged. Only x0 suppression zeroes them.
- Flush and stall together: flush wins and a bubble is inserted even if the downstream stage is stalled. This is a decided deviation from hold semantics.
- Counters:
  - bubble_cnt increments on each bubble cycle.
  - hold_cnt increments on each hold cycle.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr zeroes both counters and overrides an increment in the same cycle. cnt_clr does not affect the data path.
- Reset asserted during a held state clears everything on that edge. No residual state survives reset.
- LANES=1: no WAW logic is generated. Behaviour equals the single-lane register plus flush and x0 suppression.

Decomposition:
- Shared defines/package: NOPRegAddr, WriteDisable/WriteEnable, ZeroWord, StallBus width, and stage-index constants (IF..WB). This block references the constants and does not redefine them.
- Sub-module sat_counter (params W; ports clk, rst, clr, inc, q), instantiated twice.
- The WAW/x0 filter is a generate loop inside this module, not a separate sub-module.

Test Plan:
- Reset: drive rst=1 with nonzero inputs for 2 cycles -> all outputs 0, wb_any=0, counters 0.
- Load, LANES=2, no stall: lane0 {wd=3,wreg=1,data=0x11}, lane1 {wd=7,wreg=1,data=0x22} -> next cycle outputs match exactly, wb_any=1.
- WAW and x0: lane0 {wd=4,wreg=1,data=0xAA}, lane1 {wd=4,wreg=1,data=0xBB} -> lane0 wreg=0 with wd=4/data=0xAA kept, lane1 wreg=1. Then lane0 wd=0,wreg=1,data=0x55 -> lane0 stores wreg=0, data=0.
- Stall vector: stall=7'b0100000 (bit5 only) -> bubble, bubble_cnt 0->1. stall=7'b1100000 for 3 cycles -> outputs held, hold_cnt=3. stall=0 -> new inputs appear after 1 cycle.
- Flush priority: stall=7'b1100000 with flush=1 -> bubble on that edge, bubble_cnt increments, hold_cnt unchanged.
- Counter saturation: CNT_W=4, 20 consecutive hold cycles -> hold_cnt stays at 15. Then cnt_clr=1 together with a hold -> hold_cnt=0.
